device_rr_scheduler: RTL

// - Shares one device port between NUM_CONTROLLERS requesters with rotating (round-robin) priority.
// - Tracks in-order outstanding reads in an ack-index FIFO and routes each device ack/data to its owner.
// - Sits between the bus controllers (CPU, PI, USB, etc.) and a single memory/register device.

---
 rtl/device_rr_scheduler_pkg.sv | 28 ++
 rtl/device_rr_scheduler_if.sv | 43 ++++
 rtl/device_rr_scheduler_ack_index_fifo.sv | 77 +++++++
 rtl/device_rr_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/device_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// device_rr_scheduler_pkg
// Shared types and helpers for the round-robin device scheduler.
//   state_e    : watchdog FSM states (RUN, FLUSH, QUIESCE)
//   SYNTH_DATA : read data returned with synthetic acks while flushing
//   clog2()    : index width helper, never returns less than 1
// -----------------------------------------------------------------------------
package device_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        QUIESCE = 2'd2
    } state_e;

    localparam logic [31:0] SYNTH_DATA = 32'hFFFF_FFFF;

    // Width needed to index n items; at least one bit so a 1-wide bus is legal.
    function automatic int clog2(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/device_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// device_rr_scheduler_if
// Bundles the requester-side and device-side signals of the scheduler.
//   master : environment view (drives requests, device responses, clear)
//   slave  : scheduler view (drives busy/ack/data and the device request)
// -----------------------------------------------------------------------------
interface device_rr_scheduler_if #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int ADDRESS_WIDTH   = 26
);
    logic [NUM_CONTROLLERS-1:0]               i_request;
    logic [NUM_CONTROLLERS-1:0]               i_write;
    logic [NUM_CONTROLLERS-1:0]               o_busy;
    logic [NUM_CONTROLLERS-1:0]               o_ack;
    logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address;
    logic [NUM_CONTROLLERS*32-1:0]            i_data;
    logic [NUM_CONTROLLERS*32-1:0]            o_data;
    logic                                     o_device_request;
    logic                                     o_device_write;
    logic                                     i_device_busy;
    logic                                     i_device_ack;
    logic [ADDRESS_WIDTH-1:0]                 o_device_address;
    logic [31:0]                              i_device_data;
    logic [31:0]                              o_device_data;
    logic                                     o_timeout;
    logic                                     i_timeout_clear;

    modport master (
        output i_request, i_write, i_address, i_data,
        output i_device_busy, i_device_ack, i_device_data, i_timeout_clear,
        input  o_busy, o_ack, o_data,
        input  o_device_request, o_device_write, o_device_address, o_device_data,
        input  o_timeout
    );

    modport slave (
        input  i_request, i_write, i_address, i_data,
        input  i_device_busy, i_device_ack, i_device_data, i_timeout_clear,
        output o_busy, o_ack, o_data,
        output o_device_request, o_device_write, o_device_address, o_device_data,
        output o_timeout
    );
endinterface

// File: rtl/device_rr_scheduler_ack_index_fifo.sv
// -----------------------------------------------------------------------------
// ack_index_fifo
// Small FIFO holding the requester index of every outstanding read, in issue
// order. Pointers carry one extra wrap bit to tell full from empty.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write an index (ignored when full)
//   pop_i        : drop the head (ignored when empty)
//   data_o       : head index
//   full_o, empty_o, count_o : occupancy status
// -----------------------------------------------------------------------------
module ack_index_fifo
    import device_rr_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);
    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1'b1);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s, pop_ok_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Next pointer values; both may advance in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q[PW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/device_rr_scheduler.sv
// -----------------------------------------------------------------------------
// device_rr_scheduler
// Shares one device port between NUM_CONTROLLERS requesters with rotating
// priority and routes in-order read acks back to their owners.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : requester request/write/address/data, busy/ack/read data,
//                    device request/write/address/data, busy/ack/read data,
//                    sticky watchdog flag and its clear
// Optional feature: define DEVICE_RR_SCHEDULER_TIMEOUT_EN to enable the ack
// watchdog (timeout -> flush outstanding reads -> quiesce -> run).
// -----------------------------------------------------------------------------
module device_rr_scheduler
    import device_rr_scheduler_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int ADDRESS_WIDTH   = 26,
    parameter int ACK_FIFO_LENGTH = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input logic                  i_clk,
    input logic                  i_reset,
    device_rr_scheduler_if.slave bus
);
    localparam int N  = NUM_CONTROLLERS;
    localparam int AW = ADDRESS_WIDTH;
    localparam int IW = clog2(N);
    localparam int PW = clog2(ACK_FIFO_LENGTH);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_s;
    logic [IW-1:0] head_s;
    logic [N-1:0]  grant_oh_s;
    logic [N-1:0]  ack_oh_s;
    logic          any_req_s, run_s, flush_s, write_g_s;
    logic          issue_s, push_s, pop_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [PW:0]   fifo_count_s;
    logic [31:0]   rdata_s;
    state_e        state_s;

    // First requester at or after the rotating pointer, wrapping around.
    always_comb begin : grant_comb
        int  idx;
        logic found;
        grant_s = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && bus.i_request[idx]) begin
                grant_s = IW'(idx);
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    end

    assign any_req_s = |bus.i_request;
    assign run_s     = (state_s == RUN);
    assign flush_s   = (state_s == FLUSH);
    assign write_g_s = bus.i_write[grant_s];

    // A read may only issue with a free FIFO slot; a same-cycle pop does not help.
    assign issue_s = any_req_s && run_s && !i_reset && !bus.i_device_busy &&
                     (write_g_s || !fifo_full_s);
    assign push_s  = issue_s && !write_g_s;

    // Normal acks pop only when something is outstanding; flushing drains unconditionally.
    always_comb begin
        pop_s = 1'b0;
        if (i_reset) begin
            pop_s = 1'b0;
        end else if (run_s) begin
            pop_s = bus.i_device_ack && !fifo_empty_s;
        end else if (flush_s) begin
            pop_s = !fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // One-hot accept and ack vectors.
    always_comb begin
        grant_oh_s = {N{1'b0}};
        ack_oh_s   = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            grant_oh_s[k] = issue_s && (grant_s == IW'(k));
            ack_oh_s[k]   = pop_s && (head_s == IW'(k));
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (!issue_s) begin
            ptr_d = ptr_q;
        end else if (grant_s == IW'(N - 1)) begin
            ptr_d = {IW{1'b0}};
        end else begin
            ptr_d = grant_s + IW'(1'b1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ptr_q <= {IW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    ack_index_fifo #(
        .DEPTH (ACK_FIFO_LENGTH),
        .WIDTH (IW)
    ) u_ack_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (grant_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign rdata_s = flush_s ? SYNTH_DATA : bus.i_device_data;

    assign bus.o_busy           = bus.i_request & ~grant_oh_s;
    assign bus.o_ack            = ack_oh_s;
    assign bus.o_data           = {N{rdata_s}};
    assign bus.o_device_request = any_req_s && run_s && !i_reset;
    assign bus.o_device_write   = write_g_s;
    assign bus.o_device_address = bus.i_address[int'(grant_s)*AW +: AW];
    assign bus.o_device_data    = bus.i_data[int'(grant_s)*32 +: 32];

`ifdef DEVICE_RR_SCHEDULER_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [PW:0]   OCC_ONE = (PW+1)'(1'b1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          set_s;

    // Watchdog fires on the last of TIMEOUT_CYCLES ack-less cycles with reads pending.
    assign set_s = run_s && !bus.i_device_ack && !fifo_empty_s && (cnt_q == LIMIT);

    // Watchdog FSM: counter, state and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= RUN;
            cnt_q     <= {CW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.i_device_ack || fifo_empty_s) begin
                        cnt_q <= {CW{1'b0}};
                    end else if (set_s) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= FLUSH;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                FLUSH: begin
                    cnt_q <= {CW{1'b0}};
                    // Leave as the last entry drains so quiesce starts right after it.
                    if (fifo_count_s <= OCC_ONE) begin
                        state_q <= QUIESCE;
                    end
                end
                QUIESCE: begin
                    if (cnt_q == LIMIT) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= {CW{1'b0}};
                    state_q <= RUN;
                end
            endcase
            // Clear beats a same-cycle set.
            if (bus.i_timeout_clear) begin
                timeout_q <= 1'b0;
            end else if (set_s) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign state_s       = state_q;
    assign bus.o_timeout = timeout_q;
`else
    logic unused_cfg_s;

    assign state_s       = RUN;
    assign bus.o_timeout = 1'b0;
    assign unused_cfg_s  = ^{1'b0, bus.i_timeout_clear, fifo_count_s, 32'(TIMEOUT_CYCLES)};
`endif

endmodule
